clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Consumes the fractional-divided clock produced by the 5.5 clock divider and checks its frequency in the sys_clk domain.
- Synchronises the divided clock and detects its rising edges.
- Measures the sys_clk cycles spanned by a fixed number of divided-clock periods, compares the result against a programmed window, and flags loss of clock.
- Provides the on-chip self-check for the divider.

Parameters:
- EDGES, 16, number of clk_in rising-edge intervals per measurement (must be ≥2)
- CNT_W, 12, width of the measurement counter and of meas_cnt
- EXP_MIN, 86, minimum accepted meas_cnt (inclusive); default is 16 × 5.5 − 2
- EXP_MAX, 90, maximum accepted meas_cnt (inclusive)
- TIMEOUT, 32, sys_clk cycles without a clk_in rising edge before clk_lost is raised

Ports:
- sys_clk  input  1  system clock; all logic on posedge
- sys_rst_n  input  1  asynchronous active-low reset
- clk_in  input  1  divided clock under test; asynchronous to logic, treated as data only
- enable  input  1  level; 1 = run measurements
- clr_err  input  1  single-cycle pulse; clears the sticky flags
- meas_cnt  output  CNT_W  last completed measurement (sys_clk cycles)
- meas_valid  output  1  one-cycle pulse when meas_cnt updates
- freq_ok  output  1  result of the last measurement is within [EXP_MIN, EXP_MAX]
- freq_err  output  1  sticky; set by any out-of-range measurement
- clk_lost  output  1  sticky; set by timeout

Behaviour:
- Reset: asynchronous and active-low (sys_rst_n = 0). All outputs 0, FSM in IDLE, synchroniser flops 0, all counters 0.
- Input capture: clk_in passes through a 2-flop synchroniser, then a third flop. rise = s2 & ~s3. Latency from clk_in edge to rise is 2–3 sys_clk cycles.
- FSM states: IDLE, ARM, MEAS, DONE.
  - IDLE: go to ARM when enable = 1.
  - ARM: wait for rise. On rise: cyc_cnt ← 1, edge_cnt ← 0, go to MEAS.
  - MEAS: cyc_cnt increments every cycle and saturates at all-ones (never wraps). On each rise, edge_cnt increments. The rise that makes edge_cnt == EDGES goes to DONE; cyc_cnt is not incremented on that cycle.
  - DONE (one cycle): meas_cnt ← cyc_cnt; meas_valid = 1; freq_ok ← (EXP_MIN ≤ cyc_cnt ≤ EXP_MAX); freq_err set if out of range. Go to ARM if enable = 1, else IDLE.
    - The terminating edge is not re-used as the next start edge. Consecutive measurements are therefore separated by one divided-clock period.
- enable deasserted in ARM or MEAS: return to IDLE next cycle, discard the partial measurement, no meas_valid. meas_cnt and freq_ok hold their values.
- Timeout:
  - gap_cnt clears on rise and increments otherwise while state ≠ IDLE, saturating at TIMEOUT.
  - When gap_cnt reaches TIMEOUT: clk_lost ← 1, freq_ok ← 0, FSM → ARM (if enable = 1), partial measurement discarded.
  - gap_cnt is held at 0 in IDLE.
- clr_err: clears freq_err and clk_lost on the next edge. Priority: a set event in the same cycle wins (flag stays 1).
- Width rules: compare unsigned. Parameters must satisfy EXP_MAX < 2^CNT_W − 1, so a saturated count always fails.
- Jitter tolerance: synchroniser quantisation gives ±1 cycle per window edge. The window therefore spans ±2 around the nominal value.

Decomposition:
- Shared package clk_mon_pkg:
  - FSM state encoding (IDLE = 0, ARM = 1, MEAS = 2, DONE = 3)
  - default EDGES / EXP_MIN / EXP_MAX constants for the 5.5 divider
- One sub-module, sync_edge_det: 2-flop synchroniser plus rising-edge pulse. Reused for other clock-monitor instances.

Test Plan:
- Ideal 5.5 input: sys_clk 10 ns, clk_in period 55 ns, enable = 1 → meas_valid pulses every 17 clk_in periods; meas_cnt within 87..89; freq_ok = 1; freq_err = 0.
- Wrong ratio: clk_in period 60 ns (÷6) → meas_cnt = 96 ± 1; freq_ok = 0; freq_err = 1 and stays 1 after clk_in is restored to 55 ns until a clr_err pulse.
- Stopped clock: hold clk_in low mid-MEAS → clk_lost = 1 exactly 32 cycles after the last rise; no meas_valid. Restart clk_in → first new meas_valid after ARM + 16 edges.
- Enable abort: drop enable at edge 8 of a window → no meas_valid; meas_cnt unchanged. Re-enable → full 16-edge window before the next meas_valid.
- Async reset mid-MEAS: pulse sys_rst_n low for 3 ns, not aligned to sys_clk → all outputs 0 immediately; after release, FSM waits in ARM for a fresh edge.
- clr_err colliding with an out-of-range DONE in the same cycle → freq_err remains 1.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared FSM encoding and default window constants for divided-clock frequency monitors.
// Defaults describe a 16-interval window around the nominal 5.5 divider ratio (88 +/- 2).
package clk_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int DEF_EDGES   = 16;
   localparam int DEF_CNT_W   = 12;
   localparam int DEF_EXP_MIN = 86;
   localparam int DEF_EXP_MAX = 90;
   localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus a delay flop; rise pulses for one clk cycle per din rising edge.
// Latency: 2-3 clk cycles from din edge to rise; no backpressure, din is sampled every cycle.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = din;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures sys_clk cycles across EDGES divided-clock periods, checks the window, flags loss of clock.
// Result appears one cycle after the terminating rise; no backpressure, meas_valid is a bare pulse.
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int EDGES   = DEF_EDGES,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int EXP_MIN = DEF_EXP_MIN,
   parameter int EXP_MAX = DEF_EXP_MAX,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             clk_in,
   input  logic             enable,
   input  logic             clr_err,
   output logic [CNT_W-1:0] meas_cnt,
   output logic             meas_valid,
   output logic             freq_ok,
   output logic             freq_err,
   output logic             clk_lost
);

   localparam int EW = $clog2(EDGES + 1);
   localparam int GW = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(EXP_MAX);
   localparam logic [EW-1:0]    EDGE_ONE  = EW'(1);
   localparam logic [EW-1:0]    EDGE_PRE  = EW'(EDGES - 1);
   localparam logic [GW-1:0]    GAP_ONE   = GW'(1);
   localparam logic [GW-1:0]    GAP_LIMIT = GW'(TIMEOUT);
   localparam logic [GW-1:0]    GAP_PRE   = GW'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [EW-1:0]    edge_q, edge_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
   logic             meas_valid_q, meas_valid_d;
   logic             freq_ok_q, freq_ok_d;
   logic             freq_err_q, freq_err_d;
   logic             clk_lost_q, clk_lost_d;
   logic             rise;
   logic             timeout;
   logic             in_win;

   sync_edge_det u_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .din   (clk_in),
      .rise  (rise)
   );

   // A saturated count is always above WIN_HI, so it lands out of range.
   assign in_win = (cyc_q >= WIN_LO) && (cyc_q <= WIN_HI);

   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      edge_d       = edge_q;
      gap_d        = gap_q;
      meas_cnt_d   = meas_cnt_q;
      meas_valid_d = 1'b0;
      freq_ok_d    = freq_ok_q;
      freq_err_d   = freq_err_q & ~clr_err;
      clk_lost_d   = clk_lost_q & ~clr_err;
      timeout      = 1'b0;

      if (state_q == ST_IDLE || rise) begin
         gap_d = '0;
      end else if (gap_q != GAP_LIMIT) begin
         gap_d   = gap_q + GAP_ONE;
         timeout = (gap_q == GAP_PRE);
      end

      case (state_q)
         ST_IDLE: if (enable) state_d = ST_ARM;
         ST_ARM: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (rise) begin
               cyc_d   = CNT_ONE;
               edge_d  = '0;
               state_d = ST_MEAS;
            end
         end
         ST_MEAS: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (timeout) begin
               state_d = ST_ARM;
            end else if (rise && edge_q == EDGE_PRE) begin
               // Terminating edge: cycle count is frozen and published as the DONE cycle begins.
               edge_d       = edge_q + EDGE_ONE;
               state_d      = ST_DONE;
               meas_cnt_d   = cyc_q;
               meas_valid_d = 1'b1;
               freq_ok_d    = in_win;
               if (!in_win) freq_err_d = 1'b1;
            end else begin
               if (rise) edge_d = edge_q + EDGE_ONE;
               if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_ONE;
            end
         end
         default: state_d = enable ? ST_ARM : ST_IDLE;
      endcase

      if (timeout) begin
         clk_lost_d = 1'b1;
         freq_ok_d  = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         cyc_q        <= '0;
         edge_q       <= '0;
         gap_q        <= '0;
         meas_cnt_q   <= '0;
         meas_valid_q <= 1'b0;
         freq_ok_q    <= 1'b0;
         freq_err_q   <= 1'b0;
         clk_lost_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         edge_q       <= edge_d;
         gap_q        <= gap_d;
         meas_cnt_q   <= meas_cnt_d;
         meas_valid_q <= meas_valid_d;
         freq_ok_q    <= freq_ok_d;
         freq_err_q   <= freq_err_d;
         clk_lost_q   <= clk_lost_d;
      end
   end

   assign meas_cnt   = meas_cnt_q;
   assign meas_valid = meas_valid_q;
   assign freq_ok    = freq_ok_q;
   assign freq_err   = freq_err_q;
   assign clk_lost   = clk_lost_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomised bench: edge-level window model feeds a scoreboard checked on every meas_valid.
`timescale 1ns/1ps
module tb_clk_div_monitor;

   localparam int CNT_W   = 12;
   localparam int EDGES   = 16;
   localparam int EXP_MIN = 86;
   localparam int EXP_MAX = 90;
   localparam int TIMEOUT = 32;

   logic             sys_clk, sys_rst_n, clk_in, enable, clr_err;
   logic [CNT_W-1:0] meas_cnt;
   logic             meas_valid, freq_ok, freq_err, clk_lost;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int nom;
      bit ok;
   } exp_t;
   exp_t exp_q[$];

   // Window model in clk_in terms: first edge after arming starts, 16 more edges end it.
   bit     armed       = 1'b0;
   bit     counting    = 1'b0;
   bit     collide_req = 1'b0;
   int     win_edges   = 0;
   longint win_start   = 0;
   longint last_te     = 0;
   int     last_nom    = 0;
   bit     last_ok     = 1'b0;

   clk_div_monitor #(
      .EDGES   (EDGES),
      .CNT_W   (CNT_W),
      .EXP_MIN (EXP_MIN),
      .EXP_MAX (EXP_MAX),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .clk_in     (clk_in),
      .enable     (enable),
      .clr_err    (clr_err),
      .meas_cnt   (meas_cnt),
      .meas_valid (meas_valid),
      .freq_ok    (freq_ok),
      .freq_err   (freq_err),
      .clk_lost   (clk_lost)
   );

   initial begin
      sys_clk = 1'b1;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   // clr_err lands on the cycle whose rise terminates an out-of-range window.
   task automatic collide_at(input longint te);
      longint m;
      m = (te + 9) / 10;
      fork
         begin
            #(10 * (m + 1) + 1 - $time) clr_err = 1'b1;
            #10 clr_err = 1'b0;
            #4 check("clr_vs_set_freq_err", freq_err, 1);
         end
      join_none
   endtask

   task automatic edge_event(input longint te);
      exp_t e;
      last_te = te;
      if (!armed) return;
      if (!counting) begin
         counting  = 1'b1;
         win_start = te;
         win_edges = 0;
      end else begin
         win_edges++;
         if (win_edges == EDGES) begin
            e.nom = int'((te - win_start) / 10);
            e.ok  = (e.nom >= EXP_MIN) && (e.nom <= EXP_MAX);
            exp_q.push_back(e);
            last_nom = e.nom;
            last_ok  = e.ok;
            counting = 1'b0;
            if (collide_req) begin
               collide_req = 1'b0;
               collide_at(te);
            end
         end
      end
   endtask

   task automatic gen(input int period, input int n);
      for (int i = 0; i < n; i++) begin
         clk_in = 1'b1;
         edge_event($time);
         #(period / 2.0) clk_in = 1'b0;
         #(period / 2.0);
      end
   endtask

   task automatic resync();
      @(posedge sys_clk);
      #($urandom_range(4, 2));
   endtask

   task automatic restart();
      enable   = 1'b0;
      armed    = 1'b0;
      counting = 1'b0;
      repeat ($urandom_range(5, 3)) @(posedge sys_clk);
      #1 enable = 1'b1;
      armed = 1'b1;
      resync();
   endtask

   task automatic pulse_clr();
      @(posedge sys_clk);
      #1 clr_err = 1'b1;
      @(posedge sys_clk);
      #1 clr_err = 1'b0;
      #4;
   endtask

   always @(negedge sys_clk) begin
      exp_t e;
      if (sys_rst_n && meas_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_meas_valid: meas_cnt=%0d with no window expected (t=%0t)", meas_cnt, $time);
         end else begin
            e = exp_q.pop_front();
            check_range("meas_cnt", meas_cnt, e.nom - 1, e.nom + 1);
            check("freq_ok", freq_ok, e.ok);
            if (!e.ok) check("freq_err_on_bad", freq_err, 1);
         end
      end
   end

   initial begin
      longint m;
      sys_rst_n = 1'b0;
      clk_in    = 1'b0;
      enable    = 1'b0;
      clr_err   = 1'b0;

      #23;
      check("rst_meas_cnt", meas_cnt, 0);
      check("rst_meas_valid", meas_valid, 0);
      check("rst_freq_ok", freq_ok, 0);
      check("rst_freq_err", freq_err, 0);
      check("rst_clk_lost", clk_lost, 0);
      #4 sys_rst_n = 1'b1;

      // Ideal 5.5 ratio
      restart();
      gen(55, 17 * $urandom_range(3, 2));
      check("ideal_freq_err", freq_err, 0);
      check("ideal_clk_lost", clk_lost, 0);

      // Divide-by-6: out of range, sticky error
      restart();
      gen(60, 17 * 2);
      check("ratio6_freq_err", freq_err, 1);
      restart();
      gen(55, 17 * 2);
      check("restored_freq_ok", freq_ok, 1);
      check("restored_freq_err_sticky", freq_err, 1);
      pulse_clr();
      check("freq_err_cleared", freq_err, 0);

      // clr_err colliding with an out-of-range result
      restart();
      collide_req = 1'b1;
      gen(60, 17);
      pulse_clr();
      check("freq_err_cleared_after_collide", freq_err, 0);

      // Enable dropped after edge 8 of a window
      restart();
      gen(55, 8);
      enable   = 1'b0;
      armed    = 1'b0;
      counting = 1'b0;
      repeat (6) @(posedge sys_clk);
      #5;
      check_range("abort_meas_cnt_held", meas_cnt, last_nom - 1, last_nom + 1);
      check("abort_freq_ok_held", freq_ok, last_ok);
      restart();
      gen(55, 17);

      // Stopped clock mid-window
      restart();
      gen(55, 17 + $urandom_range(8, 3));
      counting = 1'b0;
      m = (last_te + 9) / 10;
      #(10 * (m + 34) - 5 - $time);
      check("clk_lost_not_early", clk_lost, 0);
      #10;
      check("clk_lost_set", clk_lost, 1);
      check("clk_lost_freq_ok", freq_ok, 0);
      #(10 * $urandom_range(30, 10));
      resync();
      gen(55, 17);
      check("clk_lost_sticky", clk_lost, 1);
      pulse_clr();
      check("clk_lost_cleared", clk_lost, 0);

      // Asynchronous reset mid-window while clk_in is low
      restart();
      gen(55, 8);
      #1 sys_rst_n = 1'b0;
      counting = 1'b0;
      #1;
      check("arst_meas_cnt", meas_cnt, 0);
      check("arst_meas_valid", meas_valid, 0);
      check("arst_freq_ok", freq_ok, 0);
      check("arst_freq_err", freq_err, 0);
      check("arst_clk_lost", clk_lost, 0);
      #2 sys_rst_n = 1'b1;
      resync();
      gen(55, 17);

      #100;
      check("pending_windows", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
